// File: rtl/sort_pkg.sv
// Shared types and default sizes for the sort engine front end, datapath and control unit.
package sort_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned ADDR_W_DEF    = 3;
  localparam int unsigned DB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } load_state_e;

endpackage

// File: rtl/sort_loader_if.sv
// Operator-side inputs and memory/control-side outputs of the sort loader.
interface sort_loader_if
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              btn_raw;
  logic [WIDTH-1:0]  sw_data;
  logic              restart;
  logic              enter;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W:0]   count;
  logic              counted;

  // Environment side: drives the button, switches and restart.
  modport master (
    output btn_raw, sw_data, restart,
    input  enter, wr_en, wr_addr, wr_data, count, counted
  );

  // Loader side.
  modport slave (
    input  btn_raw, sw_data, restart,
    output enter, wr_en, wr_addr, wr_data, count, counted
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge detector for the ENTER button.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned DC_W = $clog2(DB_CYCLES);

  logic            s1;
  logic            s;
  logic            db;
  logic            db_q;
  logic [DC_W-1:0] dc;

  // A level change is accepted only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      dc   <= '0;
    end else begin
      s1   <= btn_raw;
      s    <= s1;
      db_q <= db;
      if (s == db) begin
        dc <= '0;
      end else if (dc == DC_W'(DB_CYCLES - 1)) begin
        db <= s;
        dc <= '0;
      end else begin
        dc <= dc + DC_W'(1);
      end
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/sort_loader.sv
// Input stage of the sort engine: first press starts the control unit, later presses load
// switch values into sequential memory words until DEPTH words are stored.
module sort_loader
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  sort_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic              press;
  load_state_e       state,     state_n;
  logic              enter_q,   enter_n;
  logic              wr_en_q,   wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [WIDTH-1:0]  wr_data_q, wr_data_n;
  logic [CNT_W-1:0]  count_q,   count_n;
  logic              counted_q, counted_n;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_raw),
    .press   (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      enter_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      counted_q <= 1'b0;
    end else begin
      state     <= state_n;
      enter_q   <= enter_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      count_q   <= count_n;
      counted_q <= counted_n;
    end
  end

  // Next state and next registered outputs; strobes default low, address/data hold.
  always_comb begin
    state_n   = state;
    enter_n   = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    count_n   = count_q;
    counted_n = counted_q;
    case (state)
      IDLE: begin
        counted_n = 1'b0;
        if (press) begin
          enter_n = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        if (press) begin
          wr_en_n   = 1'b1;
          wr_addr_n = count_q[ADDR_W-1:0];
          wr_data_n = bus.sw_data;
          count_n   = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DEPTH - 1)) begin
            state_n = FULL;
          end
        end
      end
      FULL: begin
        // restart takes priority over any coincident press
        if (bus.restart) begin
          state_n   = IDLE;
          count_n   = '0;
          counted_n = 1'b0;
        end else begin
          counted_n = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        count_n   = '0;
        counted_n = 1'b0;
      end
    endcase
  end

  assign bus.enter   = enter_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.count   = count_q;
  assign bus.counted = counted_q;

endmodule

// File: tb/tb_sort_loader.sv
// Scoreboard bench for sort_loader: stimulus queues expected enter/write events, a negedge
// monitor pops and compares them whenever the loader strobes.
module tb_sort_loader;
  import sort_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sort_loader_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  sort_loader #(
    .WIDTH     (W),
    .DEPTH     (D),
    .ADDR_W    (AW),
    .DB_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   events_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_enter();
    exp_t e;
    e.is_wr = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    exp_t e;
    e.is_wr = 1'b1;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic press(input logic [W-1:0] v);
    bus.sw_data = v;
    bus.btn_raw = 1'b1;
    cyc(10);
    bus.btn_raw = 1'b0;
    cyc(10);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.enter === 1'b1 || bus.wr_en === 1'b1) begin
      events_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'({bus.enter, bus.wr_en}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 32'({bus.enter, bus.wr_en}), e.is_wr ? 32'd1 : 32'd2);
        if (e.is_wr) begin
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst         = 1'b1;
    bus.btn_raw = 1'b1;
    bus.sw_data = '0;
    bus.restart = 1'b0;
    cyc(3);
    chk("rst_enter",   32'(bus.enter),   32'd0);
    chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst_counted", 32'(bus.counted), 32'd0);
    chk("rst_count",   32'(bus.count),   32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    bus.btn_raw = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("post_rst_quiet", 32'(events_seen), 32'd0);

    // Bounce shorter than the debounce window
    bus.btn_raw = 1'b1; cyc(1);
    bus.btn_raw = 1'b0; cyc(1);
    bus.btn_raw = 1'b1; cyc(1);
    bus.btn_raw = 1'b0; cyc(12);
    chk("bounce_no_event", 32'(events_seen), 32'd0);
    chk("bounce_count",    32'(bus.count),   32'd0);

    // Clean press: enter visible after edge DB_CYCLES+3
    push_enter();
    bus.btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("enter_timing", 32'(bus.enter), 32'(k == 7));
    end
    bus.btn_raw = 1'b0;
    cyc(10);
    chk("enter_count", 32'(bus.count), 32'd0);

    // Full load
    push_wr(2'd0, 8'h3C); press(8'h3C);
    push_wr(2'd1, 8'h01); press(8'h01);
    push_wr(2'd2, 8'hFF); press(8'hFF);
    chk("count_after_3", 32'(bus.count), 32'd3);
    push_wr(2'd3, 8'h80);
    bus.sw_data = 8'h80;
    bus.btn_raw = 1'b1;
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("last_strobe_seen",   32'(bus.wr_en),   32'd1);
    chk("counted_at_strobe",  32'(bus.counted), 32'd0);
    @(negedge clk);
    chk("counted_after",      32'(bus.counted), 32'd1);
    chk("count_full",         32'(bus.count),   32'd4);
    bus.btn_raw = 1'b0;
    cyc(10);

    // FULL: extra press ignored, restart clears
    press(8'h55);
    chk("full_count_hold",   32'(bus.count),   32'd4);
    chk("full_counted_hold", 32'(bus.counted), 32'd1);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("restart_counted", 32'(bus.counted), 32'd0);
    chk("restart_count",   32'(bus.count),   32'd0);
    push_enter(); press(8'h11);
    chk("reenter_count", 32'(bus.count), 32'd0);

    // Partial load, restart ignored in FILL, then reset aborts
    push_wr(2'd0, 8'hA5); press(8'hA5);
    push_wr(2'd1, 8'h5A); press(8'h5A);
    chk("partial_count", 32'(bus.count), 32'd2);
    bus.restart = 1'b1; cyc(1);
    bus.restart = 1'b0; cyc(1);
    chk("fill_restart_ignored", 32'(bus.count), 32'd2);
    rst = 1'b1;
    cyc(1);
    chk("midrst_count",   32'(bus.count),   32'd0);
    chk("midrst_counted", 32'(bus.counted), 32'd0);
    chk("midrst_wr_en",   32'(bus.wr_en),   32'd0);
    rst = 1'b0;
    cyc(2);
    push_enter(); press(8'h77);
    chk("midrst_enter_count", 32'(bus.count), 32'd0);
    push_wr(2'd0, 8'h42); press(8'h42);
    chk("reload_count", 32'(bus.count), 32'd1);

    cyc(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
